// File: rtl/pss_correlator_multi_if.sv
// Stream bundle for the multi-sequence PSS correlator: sample input and
// per-sequence magnitude output, both with AXI-stream valid/ready.
interface pss_correlator_multi_if #(
    parameter int IN_DW  = 32,
    parameter int OUT_DW = 48,
    parameter int USER_W = 2
);
    logic [IN_DW-1:0]  s_axis_in_tdata;
    logic              s_axis_in_tvalid;
    logic              s_axis_in_tready;
    logic [OUT_DW-1:0] m_axis_out_tdata;
    logic [USER_W-1:0] m_axis_out_tuser;
    logic              m_axis_out_tlast;
    logic              m_axis_out_tvalid;
    logic              m_axis_out_tready;

    modport master (
        output s_axis_in_tdata, s_axis_in_tvalid, m_axis_out_tready,
        input  s_axis_in_tready, m_axis_out_tdata, m_axis_out_tuser,
               m_axis_out_tlast, m_axis_out_tvalid
    );

    modport slave (
        input  s_axis_in_tdata, s_axis_in_tvalid, m_axis_out_tready,
        output s_axis_in_tready, m_axis_out_tdata, m_axis_out_tuser,
               m_axis_out_tlast, m_axis_out_tvalid
    );
endinterface

// File: rtl/pss_correlator_multi.sv
// Time-multiplexed PSS correlator: each accepted sample is correlated against
// N_SEQ stored sequences, MULT_PAR complex MACs per cycle, one |corr|^2 per sequence.
module pss_correlator_multi #(
    parameter int IN_DW    = 32,
    parameter int TAP_DW   = 32,
    parameter int OUT_DW   = 48,
    parameter int PSS_LEN  = 128,
    parameter int N_SEQ    = 3,
    parameter int MULT_PAR = 16,
    parameter logic [N_SEQ*PSS_LEN*TAP_DW-1:0] PSS_LOCAL = '0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    pss_correlator_multi_if.slave bus
);
    localparam int P      = PSS_LEN / MULT_PAR;
    localparam int IH     = IN_DW / 2;
    localparam int TH     = TAP_DW / 2;
    localparam int ACC_DW = IH + TH + $clog2(PSS_LEN) + 1;
    localparam int MAG_DW = 2 * ACC_DW;
    localparam int SEQ_W  = (N_SEQ > 1) ? $clog2(N_SEQ) : 1;
    localparam int CW     = (P > 1) ? $clog2(P) : 1;
    localparam int IDX_W  = (PSS_LEN > 1) ? $clog2(PSS_LEN) : 1;
    localparam int TIDX_W = (N_SEQ * PSS_LEN > 1) ? $clog2(N_SEQ * PSS_LEN) : 1;

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t                   state;
    logic [IN_DW-1:0]         dline_p0 [PSS_LEN];
    logic [TAP_DW-1:0]        taps [N_SEQ*PSS_LEN];
    logic [CW-1:0]            chunk;
    logic [SEQ_W-1:0]         seq;
    logic signed [ACC_DW-1:0] part_re_p0, part_im_p0;
    logic signed [ACC_DW-1:0] acc_re_p1, acc_im_p1;
    logic signed [ACC_DW-1:0] sum_re, sum_im;
    logic signed [ACC_DW-1:0] x_re, x_im, t_re, t_im;
    logic [IN_DW-1:0]         x;
    logic [TAP_DW-1:0]        t;
    logic [IDX_W-1:0]         idx;
    logic [TIDX_W-1:0]        tidx;
    logic                     in_tready, vld_p2, last_p2;
    logic [OUT_DW-1:0]        data_p2;
    logic [SEQ_W-1:0]         user_p2;

    function automatic logic [OUT_DW-1:0] sat_mag(input logic signed [ACC_DW-1:0] re,
                                                  input logic signed [ACC_DW-1:0] im);
        logic signed [MAG_DW-1:0] re_w, im_w;
        logic [MAG_DW-1:0]        mag;
        re_w = MAG_DW'(re);
        im_w = MAG_DW'(im);
        mag  = $unsigned(re_w * re_w) + $unsigned(im_w * im_w);
        if ((mag >> OUT_DW) != '0) return '1;
        return mag[OUT_DW-1:0];
    endfunction

    for (genvar g = 0; g < N_SEQ * PSS_LEN; g++) begin : g_tap
        assign taps[g] = PSS_LOCAL[g*TAP_DW +: TAP_DW];
    end

    // Stage p0: one chunk of MULT_PAR complex products, selected by (seq, chunk)
    always_comb begin
        part_re_p0 = '0;
        part_im_p0 = '0;
        x = '0; t = '0; idx = '0; tidx = '0;
        x_re = '0; x_im = '0; t_re = '0; t_im = '0;
        for (int m = 0; m < MULT_PAR; m++) begin
            idx  = IDX_W'(int'(chunk) * MULT_PAR + m);
            tidx = TIDX_W'(int'(seq) * PSS_LEN + int'(chunk) * MULT_PAR + m);
            x    = dline_p0[idx];
            t    = taps[tidx];
            x_re = ACC_DW'($signed(x[IH-1:0]));
            x_im = ACC_DW'($signed(x[IN_DW-1:IH]));
            t_re = ACC_DW'($signed(t[TH-1:0]));
            t_im = ACC_DW'($signed(t[TAP_DW-1:TH]));
            part_re_p0 = part_re_p0 + x_re * t_re - x_im * t_im;
            part_im_p0 = part_im_p0 + x_re * t_im + x_im * t_re;
        end
    end

    // Stage p1: running sum; the last chunk feeds the magnitude directly
    assign sum_re = acc_re_p1 + part_re_p0;
    assign sum_im = acc_im_p1 + part_im_p0;

    // Stage p2: registered output, held while the consumer stalls
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= IDLE;
            chunk     <= '0;
            seq       <= '0;
            in_tready <= 1'b0;
            vld_p2    <= 1'b0;
            data_p2   <= '0;
            user_p2   <= '0;
            last_p2   <= 1'b0;
            acc_re_p1 <= '0;
            acc_im_p1 <= '0;
            for (int i = 0; i < PSS_LEN; i++) dline_p0[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.s_axis_in_tvalid && in_tready) begin
                        dline_p0[0] <= bus.s_axis_in_tdata;
                        for (int i = 1; i < PSS_LEN; i++) dline_p0[i] <= dline_p0[i-1];
                        seq       <= '0;
                        chunk     <= '0;
                        in_tready <= 1'b0;
                        state     <= ACC;
                    end else begin
                        in_tready <= 1'b1;
                    end
                end
                ACC: begin
                    acc_re_p1 <= sum_re;
                    acc_im_p1 <= sum_im;
                    if (chunk == CW'(P - 1)) begin
                        vld_p2  <= 1'b1;
                        data_p2 <= sat_mag(sum_re, sum_im);
                        user_p2 <= seq;
                        last_p2 <= (seq == SEQ_W'(N_SEQ - 1));
                        state   <= OUT;
                    end else begin
                        chunk <= chunk + CW'(1);
                    end
                end
                OUT: begin
                    if (bus.m_axis_out_tready) begin
                        vld_p2    <= 1'b0;
                        acc_re_p1 <= '0;
                        acc_im_p1 <= '0;
                        chunk     <= '0;
                        if (seq == SEQ_W'(N_SEQ - 1)) begin
                            in_tready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            seq   <= seq + SEQ_W'(1);
                            state <= ACC;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s_axis_in_tready  = in_tready;
    assign bus.m_axis_out_tvalid = vld_p2;
    assign bus.m_axis_out_tdata  = data_p2;
    assign bus.m_axis_out_tuser  = user_p2;
    assign bus.m_axis_out_tlast  = last_p2;
endmodule

// File: tb/tb_pss_correlator_multi.sv
// Directed bench for pss_correlator_multi: a default-width instance and a
// 16-bit-output instance run in lockstep on the same input stream.
`timescale 1ns/1ps
module tb_pss_correlator_multi;
    localparam int IN_DW    = 32;
    localparam int TAP_DW   = 32;
    localparam int OUT_DW   = 48;
    localparam int SAT_DW   = 16;
    localparam int PSS_LEN  = 128;
    localparam int N_SEQ    = 3;
    localparam int MULT_PAR = 16;
    localparam int USER_W   = 2;
    localparam logic [N_SEQ*PSS_LEN*TAP_DW-1:0] TAPS_MAIN =
        {{PSS_LEN{32'h0000_0000}}, {PSS_LEN{32'h0001_0000}}, {PSS_LEN{32'h0000_0001}}};
    localparam logic [N_SEQ*PSS_LEN*TAP_DW-1:0] TAPS_SAT = {(N_SEQ*PSS_LEN){32'h0000_7FFF}};

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    logic [OUT_DW-1:0] got_d [N_SEQ];
    logic [USER_W-1:0] got_u [N_SEQ];
    logic              got_l [N_SEQ];
    logic [SAT_DW-1:0] sat_d [N_SEQ];
    logic              sat_v [N_SEQ];

    always #5 clk = ~clk;

    pss_correlator_multi_if #(.IN_DW(IN_DW), .OUT_DW(OUT_DW), .USER_W(USER_W)) bus ();
    pss_correlator_multi_if #(.IN_DW(IN_DW), .OUT_DW(SAT_DW), .USER_W(USER_W)) sbus ();

    assign sbus.s_axis_in_tdata   = bus.s_axis_in_tdata;
    assign sbus.s_axis_in_tvalid  = bus.s_axis_in_tvalid;
    assign sbus.m_axis_out_tready = bus.m_axis_out_tready;

    pss_correlator_multi #(
        .IN_DW(IN_DW), .TAP_DW(TAP_DW), .OUT_DW(OUT_DW), .PSS_LEN(PSS_LEN),
        .N_SEQ(N_SEQ), .MULT_PAR(MULT_PAR), .PSS_LOCAL(TAPS_MAIN)
    ) dut (.clk_i(clk), .reset_i(rst), .bus(bus));

    pss_correlator_multi #(
        .IN_DW(IN_DW), .TAP_DW(TAP_DW), .OUT_DW(SAT_DW), .PSS_LEN(PSS_LEN),
        .N_SEQ(N_SEQ), .MULT_PAR(MULT_PAR), .PSS_LOCAL(TAPS_SAT)
    ) dut_sat (.clk_i(clk), .reset_i(rst), .bus(sbus));

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [IN_DW-1:0] d);
        int w;
        w = 0;
        bus.s_axis_in_tdata  = d;
        bus.s_axis_in_tvalid = 1'b1;
        while (bus.s_axis_in_tready !== 1'b1 && w < 100) begin step(); w++; end
        if (bus.s_axis_in_tready !== 1'b1) begin
            n_checks++;
            $display("FAIL send_timeout: tready=%b required 1", bus.s_axis_in_tready);
        end
        step();
        bus.s_axis_in_tvalid = 1'b0;
    endtask

    task automatic collect();
        int w;
        for (int s = 0; s < N_SEQ; s++) begin
            w = 0;
            while (bus.m_axis_out_tvalid !== 1'b1 && w < 40) begin step(); w++; end
            if (bus.m_axis_out_tvalid !== 1'b1) begin
                n_checks++;
                $display("FAIL collect_timeout seq=%0d: tvalid=%b required 1", s, bus.m_axis_out_tvalid);
                return;
            end
            got_d[s] = bus.m_axis_out_tdata;
            got_u[s] = bus.m_axis_out_tuser;
            got_l[s] = bus.m_axis_out_tlast;
            sat_d[s] = sbus.m_axis_out_tdata;
            sat_v[s] = sbus.m_axis_out_tvalid;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.s_axis_in_tvalid  = 1'b1;
        bus.s_axis_in_tdata   = 32'h0000_0001;
        bus.m_axis_out_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (bus.s_axis_in_tready !== 1'b0) $display("FAIL rst_tready cyc%0d: got %b want 0", i, bus.s_axis_in_tready);
            else n_pass++;
            n_checks++;
            if (bus.m_axis_out_tvalid !== 1'b0) $display("FAIL rst_tvalid cyc%0d: got %b want 0", i, bus.m_axis_out_tvalid);
            else n_pass++;
            n_checks++;
            if (bus.m_axis_out_tdata !== '0) $display("FAIL rst_tdata cyc%0d: got %h want 0", i, bus.m_axis_out_tdata);
            else n_pass++;
            n_checks++;
            if (bus.m_axis_out_tuser !== '0) $display("FAIL rst_tuser cyc%0d: got %0d want 0", i, bus.m_axis_out_tuser);
            else n_pass++;
            n_checks++;
            if (bus.m_axis_out_tlast !== 1'b0) $display("FAIL rst_tlast cyc%0d: got %b want 0", i, bus.m_axis_out_tlast);
            else n_pass++;
        end
        rst = 1'b0;
        bus.s_axis_in_tvalid = 1'b0;
        step();
        n_checks++;
        if (bus.s_axis_in_tready !== 1'b1) $display("FAIL rst_release_tready: got %b want 1", bus.s_axis_in_tready);
        else n_pass++;
    endtask

    task automatic test_constant();
        logic [OUT_DW-1:0] e;
        for (int k = 1; k <= PSS_LEN; k++) begin
            send(32'h0000_0001);
            collect();
            e = OUT_DW'(k * k);
            for (int s = 0; s < N_SEQ; s++) begin
                n_checks++;
                if (got_d[s] !== ((s == 2) ? '0 : e))
                    $display("FAIL const_k%0d_seq%0d: got %0d want %0d", k, s, got_d[s], (s == 2) ? 0 : k * k);
                else n_pass++;
                n_checks++;
                if (got_u[s] !== USER_W'(s)) $display("FAIL const_tuser k%0d: got %0d want %0d", k, got_u[s], s);
                else n_pass++;
                n_checks++;
                if (got_l[s] !== (s == N_SEQ - 1)) $display("FAIL const_tlast k%0d seq%0d: got %b", k, s, got_l[s]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_latency();
        int acc_cyc[$];
        int hs_cyc[$];
        int w;
        logic [OUT_DW-1:0] e;
        cyc = 0;
        bus.s_axis_in_tdata   = 32'h0000_0001;
        bus.s_axis_in_tvalid  = 1'b1;
        bus.m_axis_out_tready = 1'b1;
        for (int i = 0; i < 90; i++) begin
            if (bus.s_axis_in_tvalid && bus.s_axis_in_tready) acc_cyc.push_back(cyc);
            if (bus.m_axis_out_tvalid && bus.m_axis_out_tready) begin
                e = (hs_cyc.size() % 3 == 2) ? '0 : OUT_DW'(16384);
                n_checks++;
                if (bus.m_axis_out_tdata !== e) $display("FAIL lat_tdata hs%0d: got %0d want %0d", hs_cyc.size(), bus.m_axis_out_tdata, e);
                else n_pass++;
                hs_cyc.push_back(cyc);
            end
            step();
        end
        bus.s_axis_in_tvalid = 1'b0;
        w = 0;
        while (bus.s_axis_in_tready !== 1'b1 && w < 60) begin step(); w++; end
        n_checks++;
        if (acc_cyc.size() != 4) $display("FAIL lat_accept_count: got %0d want 4", acc_cyc.size());
        else n_pass++;
        n_checks++;
        if (hs_cyc.size() != 9) $display("FAIL lat_output_count: got %0d want 9", hs_cyc.size());
        else n_pass++;
        if (acc_cyc.size() >= 3 && hs_cyc.size() >= 3) begin
            n_checks++;
            if (acc_cyc[1] - acc_cyc[0] != 28) $display("FAIL lat_period0: got %0d want 28", acc_cyc[1] - acc_cyc[0]);
            else n_pass++;
            n_checks++;
            if (acc_cyc[2] - acc_cyc[1] != 28) $display("FAIL lat_period1: got %0d want 28", acc_cyc[2] - acc_cyc[1]);
            else n_pass++;
            n_checks++;
            if (hs_cyc[0] - acc_cyc[0] != 9) $display("FAIL lat_first_out: got %0d want 9", hs_cyc[0] - acc_cyc[0]);
            else n_pass++;
            n_checks++;
            if (hs_cyc[1] - acc_cyc[0] != 18) $display("FAIL lat_second_out: got %0d want 18", hs_cyc[1] - acc_cyc[0]);
            else n_pass++;
            n_checks++;
            if (hs_cyc[2] - acc_cyc[0] != 27) $display("FAIL lat_third_out: got %0d want 27", hs_cyc[2] - acc_cyc[0]);
            else n_pass++;
        end else begin
            n_checks++;
            $display("FAIL lat_timing: accepts=%0d outputs=%0d, need at least 3 each", acc_cyc.size(), hs_cyc.size());
        end
    endtask

    task automatic test_backpressure();
        int w;
        logic [OUT_DW-1:0] r0, r1, r2;
        logic l2;
        bus.m_axis_out_tready = 1'b1;
        send(32'h0002_0003);
        w = 0;
        while (bus.m_axis_out_tvalid !== 1'b1 && w < 40) begin step(); w++; end
        r0 = bus.m_axis_out_tdata;
        step();
        bus.m_axis_out_tready = 1'b0;
        w = 0;
        while (bus.m_axis_out_tvalid !== 1'b1 && w < 40) begin step(); w++; end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (bus.m_axis_out_tvalid !== 1'b1) $display("FAIL bp_tvalid cyc%0d: got %b want 1", i, bus.m_axis_out_tvalid);
            else n_pass++;
            n_checks++;
            if (bus.m_axis_out_tdata !== OUT_DW'(16904)) $display("FAIL bp_tdata cyc%0d: got %0d want 16904", i, bus.m_axis_out_tdata);
            else n_pass++;
            n_checks++;
            if (bus.m_axis_out_tuser !== USER_W'(1)) $display("FAIL bp_tuser cyc%0d: got %0d want 1", i, bus.m_axis_out_tuser);
            else n_pass++;
            n_checks++;
            if (bus.s_axis_in_tready !== 1'b0) $display("FAIL bp_s_tready cyc%0d: got %b want 0", i, bus.s_axis_in_tready);
            else n_pass++;
            step();
        end
        r1 = bus.m_axis_out_tdata;
        bus.m_axis_out_tready = 1'b1;
        step();
        w = 0;
        while (bus.m_axis_out_tvalid !== 1'b1 && w < 40) begin step(); w++; end
        r2 = bus.m_axis_out_tdata;
        l2 = bus.m_axis_out_tlast;
        step();
        n_checks++;
        if (r0 !== OUT_DW'(16904)) $display("FAIL bp_seq0: got %0d want 16904", r0);
        else n_pass++;
        n_checks++;
        if (r1 !== OUT_DW'(16904)) $display("FAIL bp_seq1: got %0d want 16904", r1);
        else n_pass++;
        n_checks++;
        if (r2 !== '0) $display("FAIL bp_seq2: got %0d want 0", r2);
        else n_pass++;
        n_checks++;
        if (l2 !== 1'b1) $display("FAIL bp_tlast: got %b want 1", l2);
        else n_pass++;
    endtask

    task automatic test_signed();
        send(32'h0000_FFFF);
        collect();
        n_checks++;
        if (got_d[0] !== OUT_DW'(16388)) $display("FAIL neg_re_seq0: got %0d want 16388", got_d[0]);
        else n_pass++;
        n_checks++;
        if (got_d[1] !== OUT_DW'(16388)) $display("FAIL neg_re_seq1: got %0d want 16388", got_d[1]);
        else n_pass++;
        send(32'hFFFF_0000);
        collect();
        n_checks++;
        if (got_d[0] !== OUT_DW'(16130)) $display("FAIL neg_im_seq0: got %0d want 16130", got_d[0]);
        else n_pass++;
        n_checks++;
        if (got_d[1] !== OUT_DW'(16130)) $display("FAIL neg_im_seq1: got %0d want 16130", got_d[1]);
        else n_pass++;
        n_checks++;
        if (got_d[2] !== '0) $display("FAIL neg_im_seq2: got %0d want 0", got_d[2]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int seen;
        send(32'h0000_0001);
        step();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.m_axis_out_tvalid !== 1'b0) seen++;
            step();
        end
        n_checks++;
        if (seen != 0) $display("FAIL abort_no_output: got %0d valid cycles want 0", seen);
        else n_pass++;
        send(32'h0000_0001);
        collect();
        n_checks++;
        if (got_d[0] !== OUT_DW'(1)) $display("FAIL impulse_seq0: got %0d want 1", got_d[0]);
        else n_pass++;
        n_checks++;
        if (got_d[1] !== OUT_DW'(1)) $display("FAIL impulse_seq1: got %0d want 1", got_d[1]);
        else n_pass++;
        n_checks++;
        if (got_d[2] !== '0) $display("FAIL impulse_seq2: got %0d want 0", got_d[2]);
        else n_pass++;
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        send(32'h0000_0000);
        collect();
        for (int s = 0; s < N_SEQ; s++) begin
            n_checks++;
            if (sat_d[s] !== '0) $display("FAIL sat_zero_seq%0d: got %h want 0", s, sat_d[s]);
            else n_pass++;
        end
        send(32'h0000_7FFF);
        collect();
        for (int s = 0; s < N_SEQ; s++) begin
            n_checks++;
            if (sat_d[s] !== 16'hFFFF || sat_v[s] !== 1'b1)
                $display("FAIL sat_full_seq%0d: got %h valid %b want ffff valid 1", s, sat_d[s], sat_v[s]);
            else n_pass++;
        end
        n_checks++;
        if (got_d[0] !== OUT_DW'(64'd1073676289)) $display("FAIL wide_seq0: got %0d want 1073676289", got_d[0]);
        else n_pass++;
        n_checks++;
        if (got_d[1] !== OUT_DW'(64'd1073676289)) $display("FAIL wide_seq1: got %0d want 1073676289", got_d[1]);
        else n_pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.s_axis_in_tdata   = '0;
        bus.s_axis_in_tvalid  = 1'b0;
        bus.m_axis_out_tready = 1'b1;
        test_reset();
        test_constant();
        test_latency();
        test_backpressure();
        test_signed();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
